// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback controller with NZCV flags.
// Optional BRANCH_LINK_EN: branch-with-link asserts link_write_o in EXECUTE.
module multicycle_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_i,
  input  logic [3:0]  nzcv_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_addr_src_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        pc_src_o,
  output logic        reg_write_src_o,
  output logic        reg_file_write_enable1_o,
  output logic        link_write_o,
  output logic [3:0]  nzcv_o,
  output logic [2:0]  state_o
);

  localparam logic [2:0] StFetch     = 3'd0;
  localparam logic [2:0] StDecode    = 3'd1;
  localparam logic [2:0] StExecute   = 3'd2;
  localparam logic [2:0] StMemory    = 3'd3;
  localparam logic [2:0] StWriteback = 3'd4;

  localparam logic [1:0] TypeDp     = 2'b00;
  localparam logic [1:0] TypeMem    = 2'b01;
  localparam logic [1:0] TypeBranch = 2'b10;
  localparam logic [1:0] TypeUndef  = 2'b11;

  logic [2:0] state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic [3:0] cond;
  logic [1:0] instr_type;
  logic       ls_bit;
  logic       cond_ok;

  assign cond       = instr_i[31:28];
  assign instr_type = instr_i[27:26];
  assign ls_bit     = instr_i[20];

  // Flags are {N,Z,C,V}; 4'hF is treated as "never" rather than unconditional.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = ~z;
      4'h2:    cond_pass = cy;
      4'h3:    cond_pass = ~cy;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = ~n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = ~v;
      4'h8:    cond_pass = cy & ~z;
      4'h9:    cond_pass = ~cy | z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = ~z & (n == v);
      4'hD:    cond_pass = z | (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign cond_ok = cond_pass(cond, flags_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    case (state_q)
      StFetch: begin
        if (mem_ready_i) state_d = StDecode;
      end
      StDecode: begin
        state_d = (cond_ok && instr_type != TypeUndef) ? StExecute : StFetch;
      end
      StExecute: begin
        case (instr_type)
          TypeDp: begin
            state_d = StWriteback;
            if (ls_bit) flags_d = nzcv_i;
          end
          TypeMem: state_d = StMemory;
          default: state_d = StFetch;
        endcase
      end
      StMemory: begin
        if (mem_ready_i) state_d = ls_bit ? StWriteback : StFetch;
      end
      StWriteback: state_d = StFetch;
      default:     state_d = StFetch;
    endcase
  end

  logic link_hit;

  // Every output is forced low while rst is held, independent of the current state.
  always_comb begin
    mem_req_o                = 1'b0;
    mem_we_o                 = 1'b0;
    mem_addr_src_o           = 1'b0;
    ir_write_o               = 1'b0;
    pc_write_o               = 1'b0;
    pc_src_o                 = 1'b0;
    reg_write_src_o          = 1'b0;
    reg_file_write_enable1_o = 1'b0;
    link_hit                 = 1'b0;
    nzcv_o                   = 4'h0;
    state_o                  = 3'd0;
    if (!rst) begin
      nzcv_o  = flags_q;
      state_o = state_q;
      case (state_q)
        StFetch: begin
          mem_req_o = 1'b1;
          if (mem_ready_i) begin
            ir_write_o = 1'b1;
            pc_write_o = 1'b1;
          end
        end
        StExecute: begin
          if (instr_type == TypeBranch) begin
            pc_write_o = 1'b1;
            pc_src_o   = 1'b1;
            link_hit   = 1'b1;
          end
        end
        StMemory: begin
          mem_req_o      = 1'b1;
          mem_addr_src_o = 1'b1;
          mem_we_o       = ~ls_bit;
        end
        StWriteback: begin
          reg_file_write_enable1_o = 1'b1;
          reg_write_src_o          = (instr_type == TypeMem);
        end
        default: ;
      endcase
    end
  end

`ifdef BRANCH_LINK_EN
  assign link_write_o = link_hit & instr_i[24];

  logic unused_instr;
  assign unused_instr = ^{instr_i[25], instr_i[23:21], instr_i[19:0]};
`else
  assign link_write_o = 1'b0;

  logic unused_instr;
  assign unused_instr = ^{instr_i[25:21], instr_i[19:0], link_hit};
`endif

endmodule
